serial_dut_harness: RTL and testbench
=====================================

SERIAL_DUT_HARNESS -- requirements
Module: serial_dut_harness

Interface
REQ-001 The block SHALL have parameter DIN_N, default 8: width of the DUT input word, legal range 2..64.
REQ-002 The block SHALL have parameter DOUT_N, default 8: width of the DUT output word, legal range 2..64.
REQ-003 The block SHALL have parameter AUTO_STB, default 0: 1 enables the internally generated frame strobe.
REQ-004 The block SHALL have parameter CAPTURE_STAGES, default 0: number of register stages on dut_out before capture, legal range 0..3.
REQ-005 The block SHALL have parameter INV_MASK, default all zeros (DIN_N bits): bits XORed onto the word presented to the DUT.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port di, input, 1 bit: serial data in.
REQ-009 The block SHALL have port stb, input, 1 bit: external frame strobe.
REQ-010 The block SHALL have port do, output, 1 bit: serial data out.
REQ-011 The block SHALL have port dut_in, output, DIN_N bits: registered parallel word driven to the DUT.
REQ-012 The block SHALL have port dut_out, input, DOUT_N bits: parallel word returned by the DUT.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after each strobe.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of strobes taken since reset.

Function
REQ-015 Every cycle, din_shr SHALL shift left one place, with di entering at bit 0.
REQ-016 Every cycle without an effective strobe, dout_shr SHALL shift left one place, with din_shr[DIN_N-1] entering at bit 0.
REQ-017 do SHALL equal dout_shr[DOUT_N-1], combinationally from the register.
REQ-018 The effective strobe eff_stb SHALL equal stb OR (AUTO_STB AND bit_cnt == FRAME_LEN-1), where FRAME_LEN = max(DIN_N, DOUT_N).
REQ-019 On eff_stb in cycle t, dut_in SHALL equal din_shr(t) XOR INV_MASK from cycle t+1 and hold until the next eff_stb.
REQ-020 On eff_stb in cycle t, dout_shr SHALL load cap(t), and the load SHALL take priority over the shift in that cycle.
REQ-021 cap SHALL be dut_out when CAPTURE_STAGES=0; otherwise cap SHALL be dut_out delayed by CAPTURE_STAGES register stages that run every cycle.
REQ-022 bit_cnt, of width clog2(FRAME_LEN), SHALL increment every cycle, wrap from FRAME_LEN-1 to 0, and clear to 0 on eff_stb.
REQ-023 When AUTO_STB=1, eff_stb SHALL therefore recur every FRAME_LEN cycles; an external stb SHALL re-phase that period.
REQ-024 When AUTO_STB=0, bit_cnt SHALL still count and SHALL NOT generate a strobe.
REQ-025 frame_done SHALL be high in cycle t+1 for each eff_stb in cycle t; strobes in back-to-back cycles SHALL give back-to-back pulses.
REQ-026 frame_cnt SHALL increment by 1 on each eff_stb and wrap from 0xFFFF to 0x0000.
REQ-027 Simultaneous external stb and auto strobe SHALL count as one strobe.
REQ-028 The din_shr shift SHALL continue during eff_stb.

Reset
REQ-029 While rst is high, din_shr, dout_shr, capture stages, dut_in, bit_cnt, frame_cnt and frame_done SHALL be 0, so do=0 and dut_in=0 (INV_MASK not applied).
REQ-030 Reset asserted mid-frame SHALL abort the frame; no frame_done pulse SHALL follow.
REQ-031 The first shift SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-032 Defaults: shift in 8'hA5 MSB first, pulse stb on the cycle after the 8th bit -> dut_in=8'hA5 and frame_done=1 the next cycle, frame_cnt=1.
REQ-033 INV_MASK=8'h40, same stimulus -> dut_in=8'hE5.
REQ-034 dut_out=8'h3C held, stb pulse, then 8 cycles -> do emits 0,0,1,1,1,1,0,0 starting the cycle after stb.
REQ-035 AUTO_STB=1, DIN_N=4, DOUT_N=6 -> frame_done every 6 cycles; an external stb at bit_cnt=2 -> next auto pulse 6 cycles after that stb.
REQ-036 CAPTURE_STAGES=2, dut_out changes 8'h00->8'hFF one cycle before stb -> captured word 8'h00; the same change 2 cycles before stb -> 8'hFF.
REQ-037 rst asserted at bit_cnt=3 of an auto frame -> all outputs 0 immediately, no frame_done pulse, frame_cnt=0, counting restarts from 0.

Source files
------------

// File: rtl/serial_dut_harness.sv
// Serial-to-parallel test harness: shifts a serial word into a registered
// DUT input, captures the DUT's parallel result and shifts it back out.
// Framing comes from an external strobe, optionally also from an internal
// counter.
// The serial output port is named do_o because "do" is a reserved word.
module serial_dut_harness #(
    parameter int unsigned      DIN_N          = 8,
    parameter int unsigned      DOUT_N         = 8,
    parameter bit               AUTO_STB       = 1'b0,
    parameter int unsigned      CAPTURE_STAGES = 0,
    parameter logic [DIN_N-1:0] INV_MASK       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di,
    input  logic              stb,
    output logic              do_o,
    output logic [DIN_N-1:0]  dut_in,
    input  logic [DOUT_N-1:0] dut_out,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned FRAME_LEN = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [DIN_N-1:0]  din_shr_q,    din_shr_d;
    logic [DOUT_N-1:0] dout_shr_q,   dout_shr_d;
    logic [DIN_N-1:0]  dut_in_q,     dut_in_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [15:0]       frame_cnt_q,  frame_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [DOUT_N-1:0] cap_c;
    logic              eff_stb_c;

    // Capture path: either direct, or a free-running delay line on dut_out
    if (CAPTURE_STAGES == 0) begin : g_cap_direct
        assign cap_c = dut_out;
    end else begin : g_cap_pipe
        logic [DOUT_N-1:0] cap_q [CAPTURE_STAGES];

        // Delay line advances every cycle, independent of framing
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < CAPTURE_STAGES; i++) begin
                    cap_q[i] <= '0;
                end
            end else begin
                cap_q[0] <= dut_out;
                for (int unsigned i = 1; i < CAPTURE_STAGES; i++) begin
                    cap_q[i] <= cap_q[i-1];
                end
            end
        end

        assign cap_c = cap_q[CAPTURE_STAGES-1];
    end

    // External strobe, or the auto strobe on the last bit of a frame; both at once is one strobe
    assign eff_stb_c = stb | (AUTO_STB & (bit_cnt_q == CNT_LAST));

    // Next-state: shifters run every cycle, strobe loads dut_in/dout_shr and restarts the frame
    always_comb begin
        din_shr_d    = {din_shr_q[DIN_N-2:0], di};
        dout_shr_d   = {dout_shr_q[DOUT_N-2:0], din_shr_q[DIN_N-1]};
        dut_in_d     = dut_in_q;
        bit_cnt_d    = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        if (eff_stb_c) begin
            dout_shr_d   = cap_c;
            dut_in_d     = din_shr_q ^ INV_MASK;
            bit_cnt_d    = '0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_done_d = 1'b1;
        end
    end

    // State registers; reset clears everything, including the masked dut_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_shr_q    <= '0;
            dout_shr_q   <= '0;
            dut_in_q     <= '0;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            din_shr_q    <= din_shr_d;
            dout_shr_q   <= dout_shr_d;
            dut_in_q     <= dut_in_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign do_o       = dout_shr_q[DOUT_N-1];
    assign dut_in     = dut_in_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_dut_harness.sv
// Bench for serial_dut_harness: four instances cover default, inverted mask,
// auto-strobe and delayed-capture configurations.
module tb_serial_dut_harness;

    typedef struct packed {
        logic        do_b;
        logic [7:0]  din;
        logic        fd;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic rst, rst2;
    logic di, stb, di2, stb2, di3, stb3;
    logic [7:0] dut_out0, dut_out3;
    logic [5:0] dut_out2;
    logic do0, do1, do2, do3;
    logic [7:0] dut_in0, dut_in1, dut_in3;
    logic [3:0] dut_in2;
    logic fd0, fd1, fd2, fd3;
    logic [15:0] fc0, fc1, fc2, fc3;

    int compared   = 0;
    int mismatched = 0;
    int exp_frames = 0;

    exp_t       sb_q[$];
    logic [7:0] q_word[$];
    logic       q_bit[$];

    serial_dut_harness u_dut0 (
        .clk(clk), .rst(rst), .di(di), .stb(stb), .do_o(do0), .dut_in(dut_in0),
        .dut_out(dut_out0), .frame_done(fd0), .frame_cnt(fc0));

    serial_dut_harness #(.INV_MASK(8'h40)) u_dut1 (
        .clk(clk), .rst(rst), .di(di), .stb(stb), .do_o(do1), .dut_in(dut_in1),
        .dut_out(dut_out0), .frame_done(fd1), .frame_cnt(fc1));

    serial_dut_harness #(.DIN_N(4), .DOUT_N(6), .AUTO_STB(1'b1), .INV_MASK(4'h0)) u_dut2 (
        .clk(clk), .rst(rst2), .di(di2), .stb(stb2), .do_o(do2), .dut_in(dut_in2),
        .dut_out(dut_out2), .frame_done(fd2), .frame_cnt(fc2));

    serial_dut_harness #(.CAPTURE_STAGES(2)) u_dut3 (
        .clk(clk), .rst(rst), .di(di3), .stb(stb3), .do_o(do3), .dut_in(dut_in3),
        .dut_out(dut_out3), .frame_done(fd3), .frame_cnt(fc3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        di = 1'b0; stb = 1'b0; di2 = 1'b0; stb2 = 1'b0; di3 = 1'b0; stb3 = 1'b0;
        dut_out0 = 8'hFF; dut_out2 = 6'h00; dut_out3 = 8'hFF;
        step(); step();
        compared++; if (dut_in0 !== 8'h00) begin mismatched++; $display("FAIL reset_dut_in0 got %h want 00", dut_in0); end
        compared++; if (dut_in1 !== 8'h00) begin mismatched++; $display("FAIL reset_dut_in_mask got %h want 00", dut_in1); end
        compared++; if (do0 !== 1'b0 || do1 !== 1'b0 || do3 !== 1'b0) begin mismatched++; $display("FAIL reset_do got %b%b%b want 000", do0, do1, do3); end
        compared++; if (fd0 !== 1'b0 || fd3 !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done got %b%b want 00", fd0, fd3); end
        compared++; if (fc0 !== 16'd0 || fc3 !== 16'd0) begin mismatched++; $display("FAIL reset_frame_cnt got %h %h want 0", fc0, fc3); end
        compared++; if (dut_in2 !== 4'h0 || do2 !== 1'b0 || fc2 !== 16'd0) begin mismatched++; $display("FAIL reset_auto got %h %b %h want 0", dut_in2, do2, fc2); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] pat;
        pat = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            di = pat[i];
            step();
        end
        compared++; if (dut_in0 !== 8'h00) begin mismatched++; $display("FAIL load_hold_before got %h want 00", dut_in0); end
        di = 1'b0; stb = 1'b1;
        q_word.push_back(8'hA5);
        q_word.push_back(8'hE5);
        exp_frames++;
        step();
        stb = 1'b0;
        pat = q_word.pop_front();
        compared++; if (dut_in0 !== pat) begin mismatched++; $display("FAIL load_dut_in got %h want %h", dut_in0, pat); end
        pat = q_word.pop_front();
        compared++; if (dut_in1 !== pat) begin mismatched++; $display("FAIL load_dut_in_mask got %h want %h", dut_in1, pat); end
        compared++; if (fd0 !== 1'b1 || fd1 !== 1'b1) begin mismatched++; $display("FAIL load_frame_done got %b%b want 11", fd0, fd1); end
        compared++; if (fc0 !== 16'(exp_frames)) begin mismatched++; $display("FAIL load_frame_cnt got %0d want %0d", fc0, exp_frames); end
        step();
        compared++; if (fd0 !== 1'b0) begin mismatched++; $display("FAIL load_pulse_width got %b want 0", fd0); end
        compared++; if (dut_in0 !== 8'hA5) begin mismatched++; $display("FAIL load_hold_after got %h want a5", dut_in0); end
    endtask

    task automatic test_serial_out();
        logic [7:0] v;
        logic b;
        v = 8'h3C;
        dut_out0 = v; stb = 1'b1;
        for (int i = 7; i >= 0; i--) q_bit.push_back(v[i]);
        exp_frames++;
        step();
        stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = q_bit.pop_front();
            compared++; if (do0 !== b) begin mismatched++; $display("FAIL serial_do bit%0d got %b want %b", i, do0, b); end
            step();
        end
        compared++; if (fc0 !== 16'(exp_frames)) begin mismatched++; $display("FAIL serial_frame_cnt got %0d want %0d", fc0, exp_frames); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat, w;
        pat = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            di = pat[i];
            step();
        end
        q_word.push_back(8'hC3);
        q_word.push_back(8'h87);
        di = 1'b1; stb = 1'b1;
        exp_frames++;
        step();
        w = q_word.pop_front();
        compared++; if (fd0 !== 1'b1 || dut_in0 !== w) begin mismatched++; $display("FAIL b2b_first got %b %h want 1 %h", fd0, dut_in0, w); end
        exp_frames++;
        step();
        stb = 1'b0; di = 1'b0;
        w = q_word.pop_front();
        compared++; if (fd0 !== 1'b1 || dut_in0 !== w) begin mismatched++; $display("FAIL b2b_second got %b %h want 1 %h", fd0, dut_in0, w); end
        step();
        compared++; if (fd0 !== 1'b0) begin mismatched++; $display("FAIL b2b_end got %b want 0", fd0); end
        compared++; if (fc0 !== 16'(exp_frames)) begin mismatched++; $display("FAIL b2b_frame_cnt got %0d want %0d", fc0, exp_frames); end
    endtask

    task automatic test_random();
        logic [7:0] m_din, m_dout, m_in;
        bit loaded;
        exp_t e;
        m_din = 8'h00; m_dout = 8'h00; m_in = 8'h00; loaded = 1'b0;
        for (int c = 0; c < 72; c++) begin
            di = 1'($urandom);
            dut_out0 = 8'($urandom);
            stb = (c == 8) || (c > 8 && $urandom_range(0, 3) == 0);
            if (stb) begin
                m_dout = dut_out0;
                m_in = m_din;
                exp_frames++;
                loaded = 1'b1;
            end else begin
                m_dout = {m_dout[6:0], m_din[7]};
            end
            m_din = {m_din[6:0], di};
            sb_q.push_back('{do_b: m_dout[7], din: m_in, fd: stb, fc: 16'(exp_frames)});
            step();
            e = sb_q.pop_front();
            if (loaded) begin
                compared++; if (do0 !== e.do_b) begin mismatched++; $display("FAIL rand_do c%0d got %b want %b", c, do0, e.do_b); end
                compared++; if (dut_in0 !== e.din) begin mismatched++; $display("FAIL rand_dut_in c%0d got %h want %h", c, dut_in0, e.din); end
                compared++; if (dut_in1 !== (e.din ^ 8'h40)) begin mismatched++; $display("FAIL rand_dut_in_mask c%0d got %h want %h", c, dut_in1, e.din ^ 8'h40); end
            end
            compared++; if (fd0 !== e.fd) begin mismatched++; $display("FAIL rand_frame_done c%0d got %b want %b", c, fd0, e.fd); end
            compared++; if (fc0 !== e.fc || fc1 !== e.fc) begin mismatched++; $display("FAIL rand_frame_cnt c%0d got %0d %0d want %0d", c, fc0, fc1, e.fc); end
        end
        stb = 1'b0;
    endtask

    task automatic test_auto();
        int n;
        di2 = 1'b1; stb2 = 1'b0; dut_out2 = 6'h2A;
        rst2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (n < 20) begin step(); n++; if (fd2 === 1'b1) break; end
            compared++; if (n !== 6) begin mismatched++; $display("FAIL auto_period%0d got %0d want 6", k, n); end
        end
        compared++; if (fc2 !== 16'd2 || dut_in2 !== 4'hF) begin mismatched++; $display("FAIL auto_state got %0d %h want 2 f", fc2, dut_in2); end
        step(); step();
        stb2 = 1'b1;
        step();
        stb2 = 1'b0;
        compared++; if (fd2 !== 1'b1 || fc2 !== 16'd3) begin mismatched++; $display("FAIL auto_ext_stb got %b %0d want 1 3", fd2, fc2); end
        n = 0;
        while (n < 20) begin step(); n++; if (fd2 === 1'b1) break; end
        compared++; if (n !== 6) begin mismatched++; $display("FAIL auto_rephase got %0d want 6", n); end
        // abort a frame at bit_cnt = 3
        step(); step(); step();
        rst2 = 1'b1;
        #1;
        compared++; if (do2 !== 1'b0 || dut_in2 !== 4'h0 || fd2 !== 1'b0 || fc2 !== 16'd0) begin
            mismatched++; $display("FAIL auto_reset_now got %b %h %b %0d want 0 0 0 0", do2, dut_in2, fd2, fc2); end
        n = 0;
        for (int i = 0; i < 4; i++) begin step(); if (fd2 !== 1'b0) n++; end
        compared++; if (n !== 0) begin mismatched++; $display("FAIL auto_reset_no_pulse got %0d pulses want 0", n); end
        rst2 = 1'b0;
        n = 0;
        while (n < 20) begin step(); n++; if (fd2 === 1'b1) break; end
        compared++; if (n !== 6 || fc2 !== 16'd1) begin mismatched++; $display("FAIL auto_restart got %0d %0d want 6 1", n, fc2); end
    endtask

    task automatic test_capture();
        logic b;
        di3 = 1'b0; stb3 = 1'b0; dut_out3 = 8'h00;
        for (int k = 0; k < 2; k++) begin
            dut_out3 = 8'h00;
            for (int i = 0; i < 4; i++) step();
            dut_out3 = 8'hFF;
            step();
            if (k == 1) step();
            stb3 = 1'b1;
            for (int i = 0; i < 8; i++) q_bit.push_back(k == 1);
            step();
            stb3 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                b = q_bit.pop_front();
                compared++; if (do3 !== b) begin mismatched++; $display("FAIL capture%0d bit%0d got %b want %b", k, i, do3, b); end
                step();
            end
        end
        compared++; if (fc3 !== 16'd2 || dut_in3 !== 8'h00) begin mismatched++; $display("FAIL capture_state got %0d %h want 2 00", fc3, dut_in3); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_serial_out();
        test_back_to_back();
        test_random();
        test_auto();
        test_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
